uart_line_rx: RTL and testbench
===============================

UART_LINE_RX -- requirements
Module: uart_line_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning system clock frequency.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate from the wifi module.
REQ-003 SHALL have parameter DEPTH, default 64, meaning receive FIFO entries (power of two, 4..256).
REQ-004 SHALL have port CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port rxd  in  1  asynchronous serial input from the wifi module TX pin (GPIO_1[27] net); idle high.
REQ-007 SHALL have port rd_en  in  1  pop request for the head byte.
REQ-008 SHALL have port rd_data  out  8  head byte of the FIFO (show-ahead).
REQ-009 SHALL have port rd_valid  out  1  FIFO non-empty.
REQ-010 SHALL have port line_count  out  $clog2(DEPTH)+1  number of LF (0x0A) bytes currently held in the FIFO.
REQ-011 SHALL have port framing_err  out  1  sticky; stop bit sampled low.
REQ-012 SHALL have port overflow  out  1  sticky; byte dropped because FIFO full.
REQ-013 SHALL have port clr_err  in  1  clears framing_err and overflow.
REQ-014 SHALL have port ok_seen  out  1  one-cycle pulse on the received sequence "OK\r\n" (see Configuration).

Function
REQ-015 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 SHALL use CLKS_PER_BIT = CLK_HZ/BAUD (integer divide; 434 at defaults) as the bit period.
REQ-017 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-018 IDLE->START on synchronized rxd 1->0 edge; counter cleared.
REQ-019 START: at CLKS_PER_BIT/2 cycles resample; low -> DATA, high -> IDLE (glitch, nothing recorded).
REQ-020 DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first; after bit 7 -> STOP.
REQ-021 STOP: sample after CLKS_PER_BIT; high -> push byte, ->IDLE; low -> discard byte, set framing_err, ->WAIT_IDLE.
REQ-022 WAIT_IDLE -> IDLE when synchronized rxd is sampled high.
REQ-023 Pushed byte SHALL be visible on rd_data with rd_valid=1 one cycle after the stop-bit sample cycle.
REQ-024 rd_en with rd_valid=1 SHALL pop the head byte in that cycle; rd_en with rd_valid=0 SHALL be ignored.
REQ-025 Push while full without same-cycle pop: byte dropped, overflow set, FIFO unchanged.
REQ-026 Push while full with same-cycle pop: both performed, no overflow.
REQ-027 line_count SHALL +1 on push of 0x0A, -1 on pop of 0x0A, unchanged when both occur in the same cycle; a dropped 0x0A SHALL not count.
REQ-028 clr_err SHALL clear both sticky flags next cycle; a set event in the same cycle SHALL win.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.

Reset
REQ-030 reset SHALL force state IDLE, counters 0, FIFO empty, rd_valid=0, rd_data=0, line_count=0, framing_err=0, overflow=0, ok_seen=0, synchronizer flops=1.
REQ-031 reset mid-frame SHALL abandon the partial byte; reception resumes on the next falling edge after reset deasserts.

Configuration
REQ-032 Macro UART_LINE_RX_OK_DETECT_EN defined: a 4-byte matcher on pushed bytes pulses ok_seen one cycle after the push of the LF completing "O","K",CR,LF; any mismatching byte restarts matching (an "O" restarts at position 1).
REQ-033 Macro undefined: ok_seen SHALL be tied 0 and no matcher logic SHALL be present; port list unchanged.

Structure
REQ-034 Package uart_line_pkg SHALL hold the rx state enum and the ASCII constants (LF 0x0A, CR 0x0D, 'O' 0x4F, 'K' 0x4B).
REQ-035 FIFO SHALL be a sub-module sync_fifo (parameterized width/depth, show-ahead, full/empty outputs).

Verification
REQ-036 Send 0x55 at 115200 baud -> rd_valid rises one cycle after stop sample, rd_data=0x55, no flags.
REQ-037 Send "OK\r\n" -> 4 bytes popped in order 0x4F,0x4B,0x0D,0x0A; line_count 1 then 0 after the LF pop; ok_seen pulses once (macro on) / never (macro off).
REQ-038 Low glitch of 100 cycles on rxd -> no byte pushed, state returns IDLE.
REQ-039 Byte 0xA5 with stop bit low -> no push, framing_err=1; clr_err pulse -> 0; next good byte 0x3C received.
REQ-040 Send 65 bytes with no reads (DEPTH=64) -> 64 stored, overflow=1; pop on the cycle the 66th push occurs -> no additional drop.
REQ-041 Assert reset during DATA bit 4 -> all outputs at reset values; following frame 0x0A received, line_count=1.

Source files
------------

// File: rtl/uart_line_pkg.sv
// uart_line_pkg: receiver state encoding and ASCII constants shared by the line receiver.
package uart_line_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_e;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_K  = 8'h4B;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO; a write to a full FIFO succeeds only alongside a same-cycle read.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             wr_ok,
    output logic             rd_ok
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    always_ff @(posedge clk)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, wr_ok};
            rd_ptr <= rd_ptr + {{AW{1'b0}}, rd_ok};
        end
endmodule

// File: rtl/uart_line_rx.sv
// uart_line_rx: 8N1 receiver feeding a show-ahead FIFO with LF counting and sticky error flags.
// Define UART_LINE_RX_OK_DETECT_EN to enable the "OK\r\n" detector driving ok_seen.
module uart_line_rx
    import uart_line_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 64
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    rxd,
    input  logic                    rd_en,
    output logic [7:0]              rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  line_count,
    output logic                    framing_err,
    output logic                    overflow,
    input  logic                    clr_err,
    output logic                    ok_seen
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam int LW  = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
    rx_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic s1, rx, rx_prev, push, ferr, full, empty, wr_ok, rd_ok;
    always_ff @(posedge CLOCK_50)
        if (reset) {s1, rx, rx_prev} <= '1;
        else {s1, rx, rx_prev} <= {rxd, s1, rx};
    always_ff @(posedge CLOCK_50)
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        push    = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx) state_d = START;
            end
            START: if (cnt_q == HALF_END) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx ? IDLE : DATA;
            end
            DATA: if (cnt_q == BIT_END) begin
                cnt_d = '0;
                sh_d  = {rx, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = STOP;
            end
            STOP: if (cnt_q == BIT_END) begin
                cnt_d   = '0;
                push    = rx;
                ferr    = !rx;
                state_d = rx ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk(CLOCK_50), .rst(reset), .wr_en(push), .wr_data(sh_q), .rd_en(rd_en),
        .rd_data(rd_data), .full(full), .empty(empty), .wr_ok(wr_ok), .rd_ok(rd_ok)
    );
    assign rd_valid = !empty;
    // A set event takes priority over a simultaneous clear.
    always_ff @(posedge CLOCK_50)
        if (reset) begin
            line_count  <= '0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            line_count  <= line_count + LW'(wr_ok && sh_q == ASCII_LF) - LW'(rd_ok && rd_data == ASCII_LF);
            framing_err <= ferr ? 1'b1 : clr_err ? 1'b0 : framing_err;
            overflow    <= (push && full && !rd_ok) ? 1'b1 : clr_err ? 1'b0 : overflow;
        end
`ifdef UART_LINE_RX_OK_DETECT_EN
    logic [1:0] ok_pos;
    logic [7:0] ok_exp;
    always_comb ok_exp = ok_pos == 2'd0 ? ASCII_O : ok_pos == 2'd1 ? ASCII_K : ok_pos == 2'd2 ? ASCII_CR : ASCII_LF;
    always_ff @(posedge CLOCK_50)
        if (reset) begin
            ok_pos  <= '0;
            ok_seen <= 1'b0;
        end else begin
            ok_seen <= wr_ok && ok_pos == 2'd3 && sh_q == ASCII_LF;
            if (wr_ok) ok_pos <= sh_q == ok_exp ? ok_pos + 2'd1 : {1'b0, sh_q == ASCII_O};
        end
`else
    assign ok_seen = 1'b0;
`endif
endmodule

// File: tb/tb_uart_line_rx.sv
// tb_uart_line_rx: randomized frames checked against a queue model of the FIFO contents and flags.
module tb_uart_line_rx;
    localparam int CLK_HZ  = 1_000_000;
    localparam int BAUD    = 62_500;
    localparam int DEPTH   = 64;
    localparam int CPB     = CLK_HZ / BAUD;
    localparam int LW      = $clog2(DEPTH) + 1;
    // cycles from driving the start edge to the cycle in which the stop bit is judged
    localparam int POP_OFS = 2 + CPB / 2 + 9 * CPB;
    logic clk = 1'b0, reset = 1'b1, rxd = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] rd_data;
    logic rd_valid, framing_err, overflow, ok_seen;
    logic [LW-1:0] line_count;
    int vectors = 0, miscompares = 0, cyc = 0, pop_cycle = -1, ok_pulses = 0, ok_total = 0;
    bit drain = 1'b0, exp_ferr = 1'b0, exp_ovf = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] hist[$];

    uart_line_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .CLOCK_50(clk), .reset(reset), .rxd(rxd), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .line_count(line_count), .framing_err(framing_err),
        .overflow(overflow), .clr_err(clr_err), .ok_seen(ok_seen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ok_seen) ok_pulses <= ok_pulses + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int lf_count();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i] == 8'h0A) n++;
        return n;
    endfunction

    function automatic int count_ok();
        int n = 0;
        for (int i = 0; i + 3 < hist.size(); i++)
            if (hist[i] == 8'h4F && hist[i+1] == 8'h4B && hist[i+2] == 8'h0D && hist[i+3] == 8'h0A) n++;
        return n;
    endfunction

    // model: a good stop bit stores the byte unless the FIFO is full with no pop in the same cycle
    task automatic send(input logic [7:0] b, input bit stop_ok, input bit pop_here);
        @(posedge clk);
        #1;
        if (pop_here) pop_cycle = cyc + POP_OFS;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        if (!stop_ok) exp_ferr = 1'b1;
        else if (exp_q.size() < DEPTH || pop_here) begin
            exp_q.push_back(b);
            hist.push_back(b);
        end else exp_ovf = 1'b1;
        rxd = stop_ok;
        tick(CPB);
        rxd = 1'b1;
        tick(6);
    endtask

    task automatic quiet(input string tag);
        check({tag, ".rd_valid"}, rd_valid, exp_q.size() != 0);
        check({tag, ".line_count"}, line_count, lf_count());
        check({tag, ".framing_err"}, framing_err, exp_ferr);
        check({tag, ".overflow"}, overflow, exp_ovf);
        if (!drain && exp_q.size() != 0) check({tag, ".rd_data_head"}, rd_data, exp_q[0]);
    endtask

    task automatic reset_values(input string tag);
        check({tag, ".rd_valid"}, rd_valid, 0);
        check({tag, ".rd_data"}, rd_data, 0);
        check({tag, ".line_count"}, line_count, 0);
        check({tag, ".framing_err"}, framing_err, 0);
        check({tag, ".overflow"}, overflow, 0);
        check({tag, ".ok_seen"}, ok_seen, 0);
    endtask

    task automatic clear();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf = 1'b0;
        tick(1);
    endtask

    task automatic wait_empty(input string tag);
        drain = 1'b1;
        for (int i = 0; i < 4000 && (exp_q.size() != 0 || rd_valid); i++) tick(1);
        if (exp_q.size() != 0 || rd_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL %s.drain_timeout: %0d bytes still expected, rd_valid=%0b", tag, exp_q.size(), rd_valid);
        end
        tick(2);
        quiet(tag);
    endtask

    // monitor: every byte the DUT hands over is compared with the head of the expected queue
    initial forever begin
        @(posedge clk);
        #1;
        rd_en = (drain || cyc == pop_cycle) && rd_valid;
        if (rd_en) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rd_data: got unexpected byte %0h, expected none", rd_data);
            end else check("rd_data", rd_data, exp_q.pop_front());
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        bit ok;
        int exp_ok;
        tick(3);
        reset_values("reset");
        reset = 1'b0;
        tick(2);
        drain = 1'b1;
        send(8'h55, 1'b1, 1'b0);
        tick(4);
        quiet("byte55");
        drain = 1'b0;
        send(8'h4F, 1'b1, 1'b0);
        send(8'h4B, 1'b1, 1'b0);
        send(8'h0D, 1'b1, 1'b0);
        send(8'h0A, 1'b1, 1'b0);
        tick(2);
        quiet("ok_line");
        wait_empty("ok_drain");
        rxd = 1'b0;
        tick(CPB / 4);
        rxd = 1'b1;
        tick(2 * CPB);
        quiet("glitch");
        send(8'hC3, 1'b1, 1'b0);
        wait_empty("after_glitch");
        send(8'hA5, 1'b0, 1'b0);
        tick(4);
        quiet("framing");
        clear();
        quiet("framing_clr");
        send(8'h3C, 1'b1, 1'b0);
        wait_empty("after_framing");
        repeat (24) begin
            b = 8'($urandom);
            ok = $urandom_range(0, 7) != 0;
            send(b, ok, 1'b0);
            tick($urandom_range(0, 20));
            if (!ok) begin
                quiet("rand_bad");
                clear();
            end
        end
        wait_empty("random");
        drain = 1'b0;
        repeat (DEPTH) send(8'($urandom), 1'b1, 1'b0);
        tick(2);
        quiet("fill");
        send(8'h0A, 1'b1, 1'b0);
        tick(2);
        quiet("overflow");
        clear();
        send(8'($urandom), 1'b1, 1'b1);
        tick(2);
        quiet("full_pop_push");
        wait_empty("overflow_drain");
        drain = 1'b0;
        send(8'h0A, 1'b1, 1'b0);
        tick(2);
        quiet("pre_reset");
        @(posedge clk);
        #1;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'($urandom);
            tick(CPB);
        end
        rxd = 1'b1;
        tick(CPB / 2);
        reset = 1'b1;
        tick(2);
        reset_values("mid_frame_reset");
        ok_total += count_ok();
        hist.delete();
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovf = 1'b0;
        reset = 1'b0;
        tick(2);
        send(8'h0A, 1'b1, 1'b0);
        tick(2);
        quiet("after_reset");
        wait_empty("final");
`ifdef UART_LINE_RX_OK_DETECT_EN
        exp_ok = ok_total + count_ok();
`else
        exp_ok = 0;
`endif
        check("ok_seen_pulses", ok_pulses, exp_ok);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
